// File: rtl/bip_core.sv
// bip_core: accumulator processor core with request/acknowledge memory ports.
//
// Fetches DB-bit instructions (opcode = instr[4:0], operand = instr[DB-1:5])
// from program memory and executes them against a single accumulator. Both
// memories may insert any number of wait states via their ack inputs.
//
// Optional feature: define BIP_BRANCH_EN to add BEQ/BNE/JMP (opcodes 01000-01010).
// Without it those opcodes behave as NOPs.
//
// Ports:
//   clk       rising-edge clock
//   Clear     synchronous active-high reset; also masks all requests
//   im_addr   instruction address (= pc)
//   im_req    instruction fetch request
//   im_data   instruction word, valid with im_ack
//   im_ack    fetch complete
//   dm_addr   data address (= operand[AB-1:0])
//   dm_wdata  store data (= acc)
//   dm_rd     load request
//   dm_wr     store request
//   dm_rdata  load data, valid with dm_ack
//   dm_ack    data access complete
//   acc       accumulator (registered)
//   pc        program counter (registered)
//   halted    core stopped on HLT

module bip_core #(
    parameter int unsigned AB = 11,
    parameter int unsigned DB = 16
) (
    input  logic          clk,
    input  logic          Clear,
    output logic [AB-1:0] im_addr,
    output logic          im_req,
    input  logic [DB-1:0] im_data,
    input  logic          im_ack,
    output logic [AB-1:0] dm_addr,
    output logic [DB-1:0] dm_wdata,
    output logic          dm_rd,
    output logic          dm_wr,
    input  logic [DB-1:0] dm_rdata,
    input  logic          dm_ack,
    output logic [DB-1:0] acc,
    output logic [AB-1:0] pc,
    output logic          halted
);

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StHalt
    } state_e;

    localparam logic [4:0] OpHlt  = 5'b00000;
    localparam logic [4:0] OpSto  = 5'b00001;
    localparam logic [4:0] OpLd   = 5'b00010;
    localparam logic [4:0] OpLdi  = 5'b00011;
    localparam logic [4:0] OpAdd  = 5'b00100;
    localparam logic [4:0] OpAddi = 5'b00101;
    localparam logic [4:0] OpSub  = 5'b00110;
    localparam logic [4:0] OpSubi = 5'b00111;
`ifdef BIP_BRANCH_EN
    localparam logic [4:0] OpBeq  = 5'b01000;
    localparam logic [4:0] OpBne  = 5'b01001;
    localparam logic [4:0] OpJmp  = 5'b01010;
`endif

    state_e        state_q, state_d;
    logic [AB-1:0] pc_q, pc_d;
    logic [DB-1:0] acc_q, acc_d;
    logic [DB-1:0] ir_q, ir_d;

    logic [4:0]    opcode;
    logic [DB-6:0] operand;
    logic [DB-1:0] imm;

    assign opcode   = ir_q[4:0];
    assign operand  = ir_q[DB-1:5];
    assign imm      = {{5{operand[DB-6]}}, operand};

    assign im_addr  = pc_q;
    assign dm_addr  = operand[AB-1:0];
    assign dm_wdata = acc_q;
    assign acc      = acc_q;
    assign pc       = pc_q;
    assign halted   = (state_q == StHalt);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        ir_d    = ir_q;
        im_req  = 1'b0;
        dm_rd   = 1'b0;
        dm_wr   = 1'b0;

        case (state_q)
            StFetch: begin
                im_req = 1'b1;
                if (im_ack) begin
                    ir_d    = im_data;
                    pc_d    = pc_q + 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                // Memory opcodes override this with StExec until dm_ack.
                state_d = StFetch;
                case (opcode)
                    OpHlt: state_d = StHalt;
                    OpSto: begin
                        dm_wr = 1'b1;
                        if (!dm_ack) state_d = StExec;
                    end
                    OpLd: begin
                        dm_rd = 1'b1;
                        if (dm_ack) acc_d = dm_rdata;
                        else        state_d = StExec;
                    end
                    OpLdi: acc_d = imm;
                    OpAdd: begin
                        dm_rd = 1'b1;
                        if (dm_ack) acc_d = acc_q + dm_rdata;
                        else        state_d = StExec;
                    end
                    OpAddi: acc_d = acc_q + imm;
                    OpSub: begin
                        dm_rd = 1'b1;
                        if (dm_ack) acc_d = acc_q - dm_rdata;
                        else        state_d = StExec;
                    end
                    OpSubi: acc_d = acc_q - imm;
`ifdef BIP_BRANCH_EN
                    OpBeq: if (acc_q == '0) pc_d = operand[AB-1:0];
                    OpBne: if (acc_q != '0) pc_d = operand[AB-1:0];
                    OpJmp: pc_d = operand[AB-1:0];
`endif
                    default: ;
                endcase
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase

        // A request in flight during Clear is abandoned.
        if (Clear) begin
            im_req = 1'b0;
            dm_rd  = 1'b0;
            dm_wr  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (Clear) begin
            state_q <= StFetch;
            pc_q    <= '0;
            acc_q   <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_bip_core.sv
// tb_bip_core: self-checking bench for bip_core with behavioural program and
// data memories. Program memory acks in the request cycle; data memory acks
// after a programmable number of wait cycles (dm_dly).

module tb_bip_core;

    logic        clk = 1'b0;
    logic        Clear = 1'b1;
    logic [10:0] im_addr;
    logic        im_req;
    logic [15:0] im_data;
    logic        im_ack;
    logic [10:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_rdata;
    logic        dm_ack;
    logic [15:0] acc;
    logic [10:0] pc;
    logic        halted;

    logic [15:0] pm [0:2047];
    logic [15:0] dm [0:2047];
    int          dm_dly = 0;
    int          dm_cnt = 0;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    bip_core #(.AB(11), .DB(16)) dut (
        .clk      (clk),
        .Clear    (Clear),
        .im_addr  (im_addr),
        .im_req   (im_req),
        .im_data  (im_data),
        .im_ack   (im_ack),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rd    (dm_rd),
        .dm_wr    (dm_wr),
        .dm_rdata (dm_rdata),
        .dm_ack   (dm_ack),
        .acc      (acc),
        .pc       (pc),
        .halted   (halted)
    );

    assign im_ack   = im_req;
    assign im_data  = pm[im_addr];
    assign dm_ack   = (dm_rd | dm_wr) && (dm_cnt == dm_dly);
    assign dm_rdata = dm[dm_addr];

    always @(posedge clk) begin
        if ((dm_rd | dm_wr) && !dm_ack) dm_cnt <= dm_cnt + 1;
        else                            dm_cnt <= 0;
        if (dm_wr && dm_ack) dm[dm_addr] <= dm_wdata;
    end

    function automatic logic [15:0] enc(input logic [4:0] opc, input logic [10:0] opnd);
        return {opnd, opc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_mems(input logic [15:0] fill);
        for (int i = 0; i < 2048; i++) begin
            pm[i] = fill;
            dm[i] = 16'h0000;
        end
    endtask

    // Clear for two edges; returns at the first sample point after release.
    task automatic do_reset();
        Clear = 1'b1;
        #1;
        chk("clear_masks_req", {29'd0, im_req, dm_rd, dm_wr}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        Clear = 1'b0;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Samples: k = number of edges since release.
    task automatic run_prog(input int max_k, output int halt_k, output int wr_cycles,
                            output bit wr_stable, output bit req_after_halt,
                            output logic [10:0] wr_addr, output logic [15:0] wr_data);
        halt_k = -1;
        wr_cycles = 0;
        wr_stable = 1'b1;
        req_after_halt = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        for (int k = 0; k <= max_k; k++) begin
            if (halted && halt_k < 0) halt_k = k;
            if (halted && (im_req || dm_rd || dm_wr)) req_after_halt = 1'b1;
            if (dm_wr) begin
                if (wr_cycles == 0) begin
                    wr_addr = dm_addr;
                    wr_data = dm_wdata;
                end else if (dm_addr !== wr_addr || dm_wdata !== wr_data) begin
                    wr_stable = 1'b0;
                end
                wr_cycles++;
            end
            next_cycle();
        end
    endtask

    task automatic wait_halt(input int max_k, output int k_out);
        k_out = -1;
        for (int k = 0; k <= max_k; k++) begin
            if (halted) begin
                k_out = k;
                break;
            end
            next_cycle();
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [4:0]  opc;
        logic [10:0] opnd;
        logic [15:0] b;
        logic [15:0] exp_acc;
        logic [15:0] exp_m1;
    } vec_t;

    vec_t vecs [12];

    int          hk, wc, kk;
    bit          ws, rah;
    logic [10:0] wa;
    logic [15:0] wd;

    initial begin
        // LD 0 ; <op> ; HLT with mem[0]=a, mem[1]=b
        vecs[0]  = '{16'h1234, 5'h03, 11'h3FF, 16'h0000, 16'h03FF, 16'h0000};
        vecs[1]  = '{16'h1234, 5'h03, 11'h400, 16'h0000, 16'hFC00, 16'h0000};
        vecs[2]  = '{16'h0000, 5'h05, 11'h7FF, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[3]  = '{16'h7FFF, 5'h05, 11'h001, 16'h0000, 16'h8000, 16'h0000};
        vecs[4]  = '{16'hFFFF, 5'h04, 11'h001, 16'h0002, 16'h0001, 16'h0002};
        vecs[5]  = '{16'h0005, 5'h06, 11'h001, 16'h0007, 16'hFFFE, 16'h0007};
        vecs[6]  = '{16'h8000, 5'h07, 11'h001, 16'h0000, 16'h7FFF, 16'h0000};
        vecs[7]  = '{16'h0000, 5'h02, 11'h001, 16'hBEEF, 16'hBEEF, 16'hBEEF};
        vecs[8]  = '{16'h5A5A, 5'h01, 11'h001, 16'h0000, 16'h5A5A, 16'h5A5A};
        vecs[9]  = '{16'h1111, 5'h1F, 11'h001, 16'h2222, 16'h1111, 16'h2222};
        vecs[10] = '{16'h1111, 5'h0B, 11'h001, 16'h2222, 16'h1111, 16'h2222};
        vecs[11] = '{16'h4321, 5'h07, 11'h7FF, 16'h0000, 16'h4322, 16'h0000};

        // Reset state and first fetch
        clear_mems(16'h0000);
        dm_dly = 0;
        do_reset();
        chk("rst_im_req", {31'd0, im_req}, 32'd1);
        chk("rst_im_addr", {21'd0, im_addr}, 32'd0);
        chk("rst_acc", {16'd0, acc}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        next_cycle();
        chk("pc_after_first_ack", {21'd0, pc}, 32'd1);

        // Table-driven ALU / memory vectors, varying data-memory wait states
        for (int i = 0; i < 12; i++) begin
            clear_mems(16'h0000);
            pm[0] = enc(5'h02, 11'h000);
            pm[1] = enc(vecs[i].opc, vecs[i].opnd);
            pm[2] = enc(5'h00, 11'h000);
            dm[0] = vecs[i].a;
            dm[1] = vecs[i].b;
            dm_dly = i % 3;
            do_reset();
            wait_halt(40, kk);
            chk($sformatf("vec%0d_halt", i), {31'd0, halted}, 32'd1);
            chk($sformatf("vec%0d_acc", i), {16'd0, acc}, {16'd0, vecs[i].exp_acc});
            chk($sformatf("vec%0d_mem1", i), {16'd0, dm[1]}, {16'd0, vecs[i].exp_m1});
            chk($sformatf("vec%0d_pc", i), {21'd0, pc}, 32'd3);
        end

        // LDI 5 ; ADDI -3 ; STO 0x10 ; HLT, zero-wait and 3-wait data memory
        for (int d = 0; d < 2; d++) begin
            clear_mems(16'h0000);
            pm[0] = enc(5'h03, 11'h005);
            pm[1] = enc(5'h05, 11'h7FD);
            pm[2] = enc(5'h01, 11'h010);
            pm[3] = enc(5'h00, 11'h000);
            dm_dly = (d == 0) ? 0 : 3;
            do_reset();
            run_prog(30, hk, wc, ws, rah, wa, wd);
            chk($sformatf("sto%0d_halt_cycle", d), hk, (d == 0) ? 32'd8 : 32'd11);
            chk($sformatf("sto%0d_wr_cycles", d), wc, (d == 0) ? 32'd1 : 32'd4);
            chk($sformatf("sto%0d_wr_stable", d), {31'd0, ws}, 32'd1);
            chk($sformatf("sto%0d_addr", d), {21'd0, wa}, 32'h010);
            chk($sformatf("sto%0d_wdata", d), {16'd0, wd}, 32'h0002);
            chk($sformatf("sto%0d_mem", d), {16'd0, dm[16]}, 32'h0002);
            chk($sformatf("sto%0d_no_req_halted", d), {31'd0, rah}, 32'd0);
        end

        // Clear in the middle of a waited store abandons it
        clear_mems(16'h0000);
        pm[0] = enc(5'h03, 11'h005);
        pm[1] = enc(5'h01, 11'h010);
        pm[2] = enc(5'h00, 11'h000);
        dm_dly = 3;
        do_reset();
        repeat (4) next_cycle();
        chk("abort_wr_pending", {31'd0, dm_wr}, 32'd1);
        Clear = 1'b1;
        #1;
        chk("abort_wr_masked", {31'd0, dm_wr}, 32'd0);
        next_cycle();
        chk("abort_acc", {16'd0, acc}, 32'd0);
        chk("abort_pc", {21'd0, pc}, 32'd0);
        chk("abort_mem", {16'd0, dm[16]}, 32'd0);
        Clear = 1'b0;

        // LD 7 ; SUB 7 ; SUBI 1 with mem[7] = 0x8000
        clear_mems(16'h0000);
        pm[0] = enc(5'h02, 11'h007);
        pm[1] = enc(5'h06, 11'h007);
        pm[2] = enc(5'h07, 11'h001);
        pm[3] = enc(5'h00, 11'h000);
        dm[7] = 16'h8000;
        dm_dly = 0;
        do_reset();
        repeat (2) next_cycle();
        chk("ld7_acc", {16'd0, acc}, 32'h8000);
        repeat (2) next_cycle();
        chk("sub7_acc", {16'd0, acc}, 32'h0000);
        repeat (2) next_cycle();
        chk("subi1_acc", {16'd0, acc}, 32'hFFFF);

        // pc wrap with program memory full of NOPs: fetch n is at k = 2n
        clear_mems(enc(5'h1F, 11'h000));
        do_reset();
        for (int k = 0; k <= 4096; k++) begin
            if (k == 4092) chk("wrap_7fe", {20'd0, im_req, im_addr}, 32'h0FFE);
            if (k == 4094) chk("wrap_7ff", {20'd0, im_req, im_addr}, 32'h0FFF);
            if (k == 4096) chk("wrap_000", {20'd0, im_req, im_addr}, 32'h0800);
            if (k < 4096) next_cycle();
        end

        // BEQ taken (acc==0) and not taken (acc!=0)
        for (int t = 0; t < 2; t++) begin
            clear_mems(16'h0000);
            pm[0] = enc(5'h03, (t == 0) ? 11'h000 : 11'h001);
            pm[1] = enc(5'h08, 11'h020);
            do_reset();
            repeat (4) next_cycle();
`ifdef BIP_BRANCH_EN
            chk($sformatf("beq%0d_next_fetch", t), {20'd0, im_req, im_addr},
                (t == 0) ? 32'h0820 : 32'h0802);
`else
            chk($sformatf("beq%0d_next_fetch", t), {20'd0, im_req, im_addr}, 32'h0802);
`endif
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
